// File: rtl/gamepad_pmod_rx_pkg.sv
// Purpose : shared types and constants for the gamepad PMOD receiver.
// Contents: frame/pad widths, pad_buttons_t (same field order as btn_p1), rx_state_t,
//           and unpack_pad(), which turns 12 shifted bits into a button word.
package gamepad_pkg;

  localparam int PAD_BITS   = 12;
  localparam int FRAME_BITS = 24;
  localparam int CNT_W      = 5;

  // MSB first: {R,L,X,A,Right,Left,Down,Up,Start,Select,Y,B}, so b lands in bit 0.
  typedef struct packed {
    logic r;
    logic l;
    logic x;
    logic a;
    logic right;
    logic left;
    logic down;
    logic up;
    logic start;
    logic select;
    logic y;
    logic b;
  } pad_buttons_t;

  typedef enum logic {WAIT_SYNC, RECEIVE} rx_state_t;

  // The shifter moves bits toward the MSB, so the first bit shifted for a pad ends up
  // in the top position of its 12-bit slice. The pad protocol sends B (bit 0) first,
  // so the slice is bit-reversed to make that first bit land in bit 0.
  function automatic pad_buttons_t unpack_pad(input logic [PAD_BITS-1:0] slice);
    logic [PAD_BITS-1:0] v;
    for (int i = 0; i < PAD_BITS; i++) begin
      v[i] = slice[PAD_BITS-1-i];
    end
    return pad_buttons_t'(v);
  endfunction

endpackage

// File: rtl/gamepad_pmod_rx_if.sv
// Purpose : bundles the three PMOD pins with the decoded button/status outputs.
// Ports   : master = receiver (pins in, buttons/status out); slave = consumer/driver side.
// Latency/backpressure: n/a (wires only); outputs are never stalled.
interface gamepad_pmod_rx_if;
  import gamepad_pkg::*;

  logic         pmod_latch;
  logic         pmod_clk;
  logic         pmod_data;
  pad_buttons_t btn_p1;
  pad_buttons_t btn_p2;
  logic         frame_valid;
  logic         frame_err;
  logic         present;

  modport master (
    input  pmod_latch, pmod_clk, pmod_data,
    output btn_p1, btn_p2, frame_valid, frame_err, present
  );

  modport slave (
    output pmod_latch, pmod_clk, pmod_data,
    input  btn_p1, btn_p2, frame_valid, frame_err, present
  );

endinterface

// File: rtl/gamepad_pmod_rx_pin_sync.sv
// Purpose : synchronises one asynchronous pin into clk and flags its rising edges.
// Ports   : clk, rst_n (sync, active low), pin in; level (synced) and rise (1-cycle) out.
// Latency : pin edge seen by a clk consumer SYNC_STAGES+1 clk later; no backpressure.
module pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/gamepad_pmod_rx.sv
// Purpose : gamepad PMOD receiver; shifts 24 bits per latch frame into two SNES button words.
// Ports   : clk, rst_n (sync, active low), bus (gamepad_pmod_rx_if.master: pins in,
//           btn_p1/btn_p2/frame_valid/frame_err/present out).
// Latency : latch pin edge to button update ~SYNC_STAGES+2 clk; no backpressure, outputs free-run.
// Option  : GAMEPAD_TIMEOUT_EN clears buttons/present after TIMEOUT_CYCLES without a valid frame.
module gamepad_pmod_rx
  import gamepad_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic              clk,
  input  logic              rst_n,
  gamepad_pmod_rx_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic latch_level, latch_rise;
  logic clk_level, clk_rise;
  logic data_level, data_rise;

  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .clk(clk), .rst_n(rst_n), .pin(bus.pmod_latch), .level(latch_level), .rise(latch_rise)
  );
  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .clk(clk), .rst_n(rst_n), .pin(bus.pmod_clk), .level(clk_level), .rise(clk_rise)
  );
  pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
    .clk(clk), .rst_n(rst_n), .pin(bus.pmod_data), .level(data_level), .rise(data_rise)
  );

  logic unused_sync;
  assign unused_sync = latch_level ^ clk_level ^ data_rise;

  rx_state_t             state;
  logic [FRAME_BITS-1:0] shift;
  logic [CNT_W-1:0]      count;

`ifdef GAMEPAD_TIMEOUT_EN
  localparam int             TW     = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] T_PRE  = TW'(TIMEOUT_CYCLES - 2);

  logic [TW-1:0] timer;
  logic          frame_ok;

  assign frame_ok = (state == RECEIVE) && latch_rise && (count == CNT_FULL);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= WAIT_SYNC;
      shift           <= '0;
      count           <= '0;
      bus.btn_p1      <= '0;
      bus.btn_p2      <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.present     <= 1'b0;
`ifdef GAMEPAD_TIMEOUT_EN
      timer           <= '0;
`endif
    end else begin
      bus.frame_valid <= 1'b0;
      bus.frame_err   <= 1'b0;

      // Latch has priority: a clk edge landing in the same synced cycle is dropped.
      if (latch_rise) begin
        count <= '0;
        if (state == WAIT_SYNC) begin
          state <= RECEIVE;
        end else if (count == CNT_FULL) begin
          bus.btn_p1      <= unpack_pad(shift[FRAME_BITS-1:PAD_BITS]);
          bus.btn_p2      <= unpack_pad(shift[PAD_BITS-1:0]);
          bus.frame_valid <= 1'b1;
          bus.present     <= 1'b1;
        end else begin
          bus.frame_err <= 1'b1;
        end
      end else if (state == RECEIVE && clk_rise) begin
        shift <= {shift[FRAME_BITS-2:0], data_level};
        if (count != CNT_SAT) count <= count + CNT_W'(1);
      end

`ifdef GAMEPAD_TIMEOUT_EN
      // Only runs while a pad is believed present, so the clear happens once and the
      // receiver can resync afterwards; the timer parks at T_LAST until the next frame.
      if (frame_ok) begin
        timer <= '0;
      end else if (bus.present && timer != T_LAST) begin
        timer <= timer + TW'(1);
        if (timer == T_PRE) begin
          bus.btn_p1  <= '0;
          bus.btn_p2  <= '0;
          bus.present <= 1'b0;
          state       <= WAIT_SYNC;
        end
      end
`endif
    end
  end

endmodule
